// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port register file.
package regfile_pkg;

  localparam int unsigned RF_ADDR_W = 5;
  localparam int unsigned RF_DEPTH  = 32;
  localparam int unsigned RF_DATA_W = 32;

  typedef enum logic [0:0] {
    RF_INIT,
    RF_RUN
  } rf_state_e;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: set on issue allocation, cleared on writeback, allocation wins.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned NUM_RD = 2
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic [ADDR_W-1:0] lookup_addr_i [NUM_RD],
  output logic [NUM_RD-1:0] busy_o
);

  localparam logic [ADDR_W:0] DepthW = (ADDR_W + 1)'(DEPTH);

  logic [DEPTH-1:0] busy_q, busy_d;

  // Index 0 and indices beyond DEPTH never hold a busy bit.
  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr != '0) && ({1'b0, addr} < DepthW);
  endfunction

  always_comb begin
    busy_d = busy_q;
    if (clr_en_i && in_range(clr_addr_i)) begin
      busy_d[clr_addr_i] = 1'b0;
    end
    if (alloc_en_i && in_range(alloc_addr_i)) begin
      busy_d[alloc_addr_i] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_comb begin
    busy_o = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      if (in_range(lookup_addr_i[i])) begin
        busy_o[i] = busy_q[lookup_addr_i[i]];
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with WB bypass, busy scoreboard and sequential zero-init.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W,
  parameter int unsigned DEPTH  = RF_DEPTH,
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [ADDR_W-1:0] rd_addr_i [NUM_RD],
  output logic [DATA_W-1:0] rd_data_o [NUM_RD],
  output logic [NUM_RD-1:0] rd_busy_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              alloc_en_i,
  input  logic [ADDR_W-1:0] alloc_addr_i,
  output logic              ready_o
);

  localparam logic [ADDR_W:0]   DepthW  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  rf_state_e         state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              run;
  logic              wr_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NUM_RD-1:0] sb_busy;

  function automatic logic in_range(input logic [ADDR_W-1:0] addr);
    return (addr != '0) && ({1'b0, addr} < DepthW);
  endfunction

  assign run      = (state_q == RF_RUN);
  assign wr_valid = run && wr_en_i && in_range(wr_addr_i);
  assign ready_o  = run;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = wr_addr_i;
    mem_wdata = wr_data_i;
    unique case (state_q)
      RF_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = cnt_q;
        mem_wdata = '0;
        cnt_d     = cnt_q + ADDR_W'(1);
        if (cnt_q == LastIdx) begin
          state_d = RF_RUN;
        end
      end
      RF_RUN: begin
        mem_we = wr_valid;
      end
      default: state_d = RF_INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RF_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // No reset on storage so it can map onto RAM; INIT zeroes it instead.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .alloc_en_i    (run && alloc_en_i),
    .alloc_addr_i  (alloc_addr_i),
    .clr_en_i      (wr_valid),
    .clr_addr_i    (wr_addr_i),
    .lookup_addr_i (rd_addr_i),
    .busy_o        (sb_busy)
  );

  always_comb begin
    rd_busy_o = '0;
    for (int i = 0; i < int'(NUM_RD); i++) begin
      rd_data_o[i] = '0;
      if (run && in_range(rd_addr_i[i])) begin
        if ((BYPASS != 0) && wr_valid && (wr_addr_i == rd_addr_i[i])) begin
          rd_data_o[i] = wr_data_i;
        end else begin
          rd_data_o[i] = mem_q[rd_addr_i[i]];
          rd_busy_o[i] = sb_busy[i];
        end
      end
    end
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-read-port register file for the pipelined RISC-V core, successor to the single-cycle register file. It adds a configurable number of read ports, same-cycle write-to-read bypass, a per-register busy scoreboard for hazard detection, and a sequential zero-initialisation FSM, so storage can be inferred as RAM without a reset. It sits in the decode stage: reads feed ID/EX, writes come from WB, allocations come from issue.

## Interface
- `ADDR_W`, 5: register index width.
- `DEPTH`, 32: number of registers, at most 2**ADDR_W.
- `DATA_W`, 32: register width.
- `NUM_RD`, 2: number of read ports, 1..4.
- `BYPASS`, 1: 1 means a same-cycle WB write is forwarded to matching reads; 0 means reads return the stored value.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `rd_addr`  in  NUM_RD×ADDR_W  read indices, unpacked array [NUM_RD].
- `rd_data`  out  NUM_RD×DATA_W  read data, combinational.
- `rd_busy`  out  NUM_RD  scoreboard bit of each read index, combinational.
- `wr_en`  in  1  WB write strobe.
- `wr_addr`  in  ADDR_W  WB destination.
- `wr_data`  in  DATA_W  WB data.
- `alloc_en`  in  1  issue marks a destination pending.
- `alloc_addr`  in  ADDR_W  destination being allocated.
- `ready`  out  1  high when initialisation is complete.

## Operation
- FSM has two states: INIT and RUN. `rst_n` low forces INIT asynchronously, clears the init counter, and clears all busy bits. `ready` is 0 during reset.
- INIT: writes zero to entry `cnt` every cycle, with `cnt` running from 0 to DEPTH-1. After writing DEPTH-1 the FSM moves to RUN on the next edge. INIT is never re-entered except through reset.
- During INIT:
  - `wr_en` and `alloc_en` are ignored.
  - `rd_data` = 0 and `rd_busy` = 0.
- RUN, write: if `wr_en` is high and `wr_addr` ≠ 0, then `mem[wr_addr]` ← `wr_data` and `busy[wr_addr]` ← 0.
- RUN, alloc: if `alloc_en` is high and `alloc_addr` ≠ 0, then `busy[alloc_addr]` ← 1.
- Simultaneous write and alloc to the same index: busy ends at 1 (alloc wins, since it belongs to the younger instruction). Data is still written.
- Reads, per port i:
  - If `rd_addr[i]` = 0, data = 0 and busy = 0.
  - Otherwise, if BYPASS=1, `wr_en` is high and `wr_addr` = `rd_addr[i]`: data = `wr_data` and busy = 0.
  - Otherwise: data = `mem[rd_addr[i]]` and busy = `busy[rd_addr[i]]`.
- Alloc has no same-cycle effect on `rd_busy`; the new value is visible from the next cycle.
- Index 0 is never written and never marked busy. Indices ≥ DEPTH read as 0 and are ignored on write and alloc.
- Storage has no reset term. Only the FSM, the counter and the busy vector are reset.

## Timing
- Read latency is 0 cycles (combinational from `rd_addr`, `wr_*` and state).
- Write latency is 1 edge. With BYPASS=0, data is visible one cycle after `wr_en`. With BYPASS=1, it is visible in the same cycle.
- After `rst_n` deasserts, `ready` rises exactly DEPTH rising edges later (32 cycles by default).
- Reset asserted mid-INIT or mid-RUN takes effect immediately. Memory contents are then undefined until INIT rewrites them.
- Busy set-to-clear: an entry allocated at edge n and written at edge m>n reads busy=1 during cycles n+1..m and busy=0 after edge m. With BYPASS=1 it also reads busy=0 during cycle m itself.

## Structure
- Package `regfile_pkg` holds:
  - the typedef enum `rf_state_e` {RF_INIT, RF_RUN};
  - the default parameter constants `RF_ADDR_W`, `RF_DEPTH`, `RF_DATA_W`;
  - the typedefs `rf_addr_t` and `rf_data_t`.
- Sub-module `regfile_scoreboard` holds the busy vector and its set/clear priority logic. It exposes `NUM_RD` busy lookups and the alloc/clear ports.
- The top level holds the FSM, the init counter, the storage array and the read/bypass muxing.

## Test plan
- **Reset and init:** assert then release `rst_n` → `ready` is 0 for 32 cycles and rises on edge 32. All reads return 0 throughout, even with `wr_en`=1 to x5 during INIT.
- **Basic write and read:** write x5=0xDEADBEEF, then read port0=x5 and port1=x0 on the next cycle → 0xDEADBEEF and 0. A write of 0x1234 to x0 leaves x0 reading 0.
- **Bypass:** BYPASS=1, `wr_en` x7=0xA5A5A5A5 with port1=x7 in the same cycle → `rd_data[1]`=0xA5A5A5A5. With BYPASS=0 → the old value, then 0xA5A5A5A5 the next cycle.
- **Scoreboard:** alloc x3 → `rd_busy` for x3 is 1 from the next cycle. Write x3 three cycles later → busy is 0 (same cycle with BYPASS=1). Simultaneous alloc and write to x3 → busy stays 1 and the data is updated.
- **Multi-port:** NUM_RD=4 with x1..x4 preloaded to 1..4, read all ports at once → 1, 2, 3, 4. Alloc x0 → busy for x0 stays 0.
- **Reset mid-operation:** with x9 busy and `ready`=1, pulse `rst_n` low for 1 cycle → `ready` drops immediately, busy for x9 = 0 after init, and x9 reads 0 when `ready` reasserts 32 cycles later.
